// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int PULSE_CNT_W = 32;
    localparam int PHASE_W_DEF = 16;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable phase down-counter; expired is high while the count sits at zero.
module pulse_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a programmed number of rising edges on a masked set of lines,
// then strobes done. Configuration is captured when a run is accepted.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int NUM_SIG = 8,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PULSE_CNT_W-1:0] pulse_count,
    input  logic [PHASE_W-1:0]     high_cycles,
    input  logic [PHASE_W-1:0]     low_cycles,
    input  logic [NUM_SIG-1:0]     chan_enable,
    output logic [NUM_SIG-1:0]     pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic [PULSE_CNT_W-1:0] pulses_sent
);

    state_e                 state_q, state_d;
    logic [PULSE_CNT_W-1:0] count_q, count_d;
    logic [PHASE_W-1:0]     high_q, high_d;
    logic [PHASE_W-1:0]     low_q, low_d;
    logic [NUM_SIG-1:0]     mask_q, mask_d;
    logic [PULSE_CNT_W-1:0] sent_q, sent_d;
    logic [NUM_SIG-1:0]     pulse_q, pulse_d;
    logic                   done_q, done_d;
    logic                   tmr_load;
    logic [PHASE_W-1:0]     tmr_val;
    logic                   tmr_expired;

    // A zero-length phase behaves as one cycle; timer counts length-1 down to 0.
    function automatic logic [PHASE_W-1:0] phase_load(input logic [PHASE_W-1:0] len);
        return (len == '0) ? '0 : len - PHASE_W'(1);
    endfunction

    pulse_phase_timer #(.W(PHASE_W)) u_timer (
        .clk      (axi_clk),
        .rst      (axi_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state, config capture, edge counting and registered output values.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        high_d   = high_q;
        low_d    = low_q;
        mask_d   = mask_q;
        sent_d   = sent_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                // stop beats a simultaneous start
                if (start && !stop) begin
                    count_d = pulse_count;
                    high_d  = high_cycles;
                    low_d   = low_cycles;
                    mask_d  = chan_enable;
                    sent_d  = '0;
                    if (pulse_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = phase_load(high_cycles);
                    end
                end
            end
            HIGH: begin
                if (stop) begin
                    state_d = DONE;
                end else if (tmr_expired) begin
                    // no trailing low phase after the final pulse
                    if (sent_q == count_q) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = phase_load(low_q);
                    end
                end
            end
            LOW: begin
                if (stop) begin
                    state_d = DONE;
                end else if (tmr_expired) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(high_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Each entry into HIGH is one emitted rising edge.
        if (state_d == HIGH && state_q != HIGH) begin
            sent_d = sent_d + PULSE_CNT_W'(1);
        end
        pulse_d = (state_d == HIGH) ? mask_d : '0;
        done_d  = (state_d == DONE);
    end

    // State, config latches and output registers.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
            mask_q  <= '0;
            sent_q  <= '0;
            pulse_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            high_q  <= high_d;
            low_q   <= low_d;
            mask_q  <= mask_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: table of directed runs, hand-written corner
// sequences and random runs, all checked cycle by cycle against a waveform
// built from the pulse/phase rules.
module tb_pulse_train_gen;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic        stop;
    logic [31:0] pulse_count;
    logic [15:0] high_cycles;
    logic [15:0] low_cycles;
    logic [7:0]  chan_enable;
    logic [7:0]  pulse_out;
    logic        busy;
    logic        done;
    logic [31:0] pulses_sent;

    int checks   = 0;
    int failures = 0;

    pulse_train_gen #(.NUM_SIG(8), .PHASE_W(16)) dut (
        .axi_clk     (axi_clk),
        .axi_reset   (axi_reset),
        .start       (start),
        .stop        (stop),
        .pulse_count (pulse_count),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .chan_enable (chan_enable),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [31:0] cnt;
        logic [15:0] h;
        logic [15:0] l;
        logic [7:0]  m;
        int          stop_at;
        int          exp_done;
        logic [31:0] exp_sent;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One run from an IDLE cycle. stop_at = cycle (1 = first cycle after the
    // accepting edge) during which stop is held; 0 = never. fuzz scrambles the
    // config inputs and holds start high while the run is in progress.
    task automatic do_run(input logic [31:0] cnt, input logic [15:0] h, input logic [15:0] l,
                          input logic [7:0] m, input int stop_at, input bit fuzz,
                          output int done_at, output logic [31:0] sent_fin);
        logic [7:0]  ep[$];
        logic [31:0] es[$];
        int          hm, lm, n;
        logic [31:0] fin;
        hm = (h == 16'd0) ? 1 : int'(h);
        lm = (l == 16'd0) ? 1 : int'(l);
        for (int p = 1; p <= int'(cnt); p++) begin
            for (int i = 0; i < hm; i++) begin ep.push_back(m); es.push_back(32'(p)); end
            if (p < int'(cnt))
                for (int i = 0; i < lm; i++) begin ep.push_back(8'h00); es.push_back(32'(p)); end
        end
        if (stop_at > 0) while (ep.size() > stop_at) begin void'(ep.pop_back()); void'(es.pop_back()); end
        n   = ep.size();
        fin = (n == 0) ? 32'd0 : es[n-1];

        pulse_count = cnt; high_cycles = h; low_cycles = l; chan_enable = m;
        start = 1'b1; stop = 1'b0;
        tick();
        start = fuzz;
        done_at = -1;
        for (int c = 1; c <= n + 1; c++) begin
            chk("run_cycle", {22'd0, pulse_out, done, busy, pulses_sent},
                {22'd0, (c <= n) ? ep[c-1] : 8'h00, (c == n + 1), 1'b1, (c <= n) ? es[c-1] : fin});
            if (done && done_at < 0) done_at = c;
            stop = (c == stop_at);
            if (fuzz) begin
                pulse_count = $urandom; high_cycles = 16'($urandom);
                low_cycles = 16'($urandom); chan_enable = 8'($urandom);
            end
            tick();
        end
        start = 1'b0; stop = 1'b0;
        chk("idle_after_done", {22'd0, pulse_out, done, busy, pulses_sent}, {22'd0, 8'h00, 1'b0, 1'b0, fin});
        sent_fin = pulses_sent;
    endtask

    initial begin
        int          d;
        logic [31:0] s;

        axi_reset = 1'b1; start = 1'b0; stop = 1'b0;
        pulse_count = '0; high_cycles = '0; low_cycles = '0; chan_enable = '0;
        tick(); tick();
        chk("reset_state", {22'd0, pulse_out, done, busy, pulses_sent}, 64'd0);
        axi_reset = 1'b0;
        tick();
        chk("idle_after_reset", {22'd0, pulse_out, done, busy, pulses_sent}, 64'd0);

        // {count, H, L, mask, stop_at, done cycle, final sent}
        vecs.push_back('{32'd3,   16'd2, 16'd3, 8'h01, 0,  13, 32'd3});
        vecs.push_back('{32'd0,   16'd5, 16'd5, 8'hFF, 0,  1,  32'd0});
        vecs.push_back('{32'd1,   16'd0, 16'd0, 8'hFF, 0,  2,  32'd1});
        vecs.push_back('{32'd100, 16'd4, 16'd4, 8'h0F, 18, 19, 32'd3});
        vecs.push_back('{32'd2,   16'd1, 16'd1, 8'h00, 0,  4,  32'd2});
        vecs.push_back('{32'd1,   16'd3, 16'd5, 8'hAA, 0,  4,  32'd1});
        vecs.push_back('{32'd4,   16'd1, 16'd2, 8'h55, 11, 11, 32'd4});
        vecs.push_back('{32'd5,   16'd2, 16'd3, 8'hC3, 4,  5,  32'd1});
        foreach (vecs[i]) begin
            do_run(vecs[i].cnt, vecs[i].h, vecs[i].l, vecs[i].m, vecs[i].stop_at, 1'b0, d, s);
            chk("vec_done_cycle", 64'(d), 64'(vecs[i].exp_done));
            chk("vec_sent", 64'(s), 64'(vecs[i].exp_sent));
        end

        // start held high and config churning during a run
        do_run(32'd5, 16'd2, 16'd2, 8'h3C, 0, 1'b1, d, s);
        chk("fuzz_sent", 64'(s), 64'd5);

        // start and stop together in IDLE: nothing happens, count holds
        start = 1'b1; stop = 1'b1; pulse_count = 32'd3; chan_enable = 8'hFF;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", {22'd0, pulse_out, done, busy, pulses_sent}, {22'd0, 8'h00, 1'b0, 1'b0, 32'd5});
        tick();
        chk("start_stop_idle2", {22'd0, pulse_out, done, busy, pulses_sent}, {22'd0, 8'h00, 1'b0, 1'b0, 32'd5});

        // reset in the middle of a LOW phase
        pulse_count = 32'd5; high_cycles = 16'd2; low_cycles = 16'd4; chan_enable = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("in_low_phase", {30'd0, pulse_out, busy, pulses_sent[15:0]}, {30'd0, 8'h00, 1'b1, 16'd1});
        axi_reset = 1'b1;
        tick();
        chk("reset_mid_low", {22'd0, pulse_out, done, busy, pulses_sent}, 64'd0);
        axi_reset = 1'b0;
        tick();
        chk("no_done_after_reset", {22'd0, pulse_out, done, busy, pulses_sent}, 64'd0);
        do_run(32'd2, 16'd3, 16'd1, 8'h81, 0, 1'b0, d, s);
        chk("after_reset_done_cycle", 64'(d), 64'd8);

        // random back-to-back runs
        for (int k = 0; k < 25; k++) begin
            logic [31:0] rc;
            logic [15:0] rh, rl;
            int          rs;
            rc = 32'($urandom_range(0, 6));
            rh = 16'($urandom_range(0, 4));
            rl = 16'($urandom_range(0, 4));
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
            do_run(rc, rh, rl, 8'($urandom), rs, 1'($urandom), d, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
